// File: rtl/systolic_tile_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// systolic_tile_ctrl_if : scheduler handshake plus RAM / PE control bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface systolic_tile_ctrl_if #(
  parameter int N      = 2,
  parameter int ADDR_W = 8,
  parameter int K_W    = 8
) ();
  logic                  start;
  logic [K_W-1:0]        k_len;
  logic [ADDR_W-1:0]     base_w;
  logic [ADDR_W-1:0]     base_a;
  logic                  stall;
  logic                  busy;
  logic                  done;
  logic [N*ADDR_W-1:0]   ram_w_addr;
  logic [N*ADDR_W-1:0]   ram_a_addr;
  logic [N-1:0]          ram_w_rden;
  logic [N-1:0]          ram_a_rden;
  logic [N*N-1:0]        en_mult;
  logic [N*N-1:0]        clr_mult;
  logic [N*N-1:0]        en_accum;
  logic [N*N-1:0]        clr_accum;

  modport master (
    output start, k_len, base_w, base_a, stall,
    input  busy, done, ram_w_addr, ram_a_addr, ram_w_rden, ram_a_rden,
    input  en_mult, clr_mult, en_accum, clr_accum
  );

  modport slave (
    input  start, k_len, base_w, base_a, stall,
    output busy, done, ram_w_addr, ram_a_addr, ram_w_rden, ram_a_rden,
    output en_mult, clr_mult, en_accum, clr_accum
  );
endinterface
`default_nettype wire

// File: rtl/systolic_tile_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// systolic_tile_ctrl : skewed RAM-read and PE-enable sequencer for an NxN tile
// Rev 1.0
// ---------------------------------------------------------------------------
module systolic_tile_ctrl #(
  parameter int N       = 2,
  parameter int ADDR_W  = 8,
  parameter int K_W     = 8,
  parameter int RD_LAT  = 1,
  parameter int MUL_LAT = 1
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  systolic_tile_ctrl_if.slave  bus
);

  localparam int SKEW = 2 * (N - 1) + RD_LAT + MUL_LAT;
  localparam int TMAX = (1 << K_W) - 1 + SKEW;
  localparam int T_W  = $clog2(TMAX + 1);
  // one spare bit so window upper bounds never wrap
  localparam int C_W  = T_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_STALL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q;
  logic [T_W-1:0]      t_q;
  logic [K_W-1:0]      k_q;
  logic [ADDR_W-1:0]   bw_q;
  logic [ADDR_W-1:0]   ba_q;
  logic [ADDR_W-1:0]   w_addr_q [N];
  logic [ADDR_W-1:0]   a_addr_q [N];

  logic                w_active;
  logic                w_last;
  logic [C_W-1:0]      w_t;
  logic [C_W-1:0]      w_k;
  logic [N-1:0]        w_w_rden;
  logic [N-1:0]        w_a_rden;
  logic [ADDR_W-1:0]   w_w_addr [N];
  logic [ADDR_W-1:0]   w_a_addr [N];
  logic [N*N-1:0]      w_en_mult;
  logic [N*N-1:0]      w_en_accum;

  assign w_t = C_W'(t_q);
  assign w_k = C_W'(k_q);

  // STALL only differs from RUN while stall is still high; a released stall issues this cycle
  assign w_active = ((state_q == S_RUN) || (state_q == S_STALL)) && !bus.stall;
  assign w_last   = (w_t + C_W'(1)) == (w_k + C_W'(SKEW));

  generate
    for (genvar l = 0; l < N; l++) begin : g_line
      assign w_w_rden[l] = w_active && (w_t >= C_W'(l)) && (w_t < C_W'(l) + w_k);
      assign w_a_rden[l] = w_w_rden[l];
      assign w_w_addr[l] = bw_q + ADDR_W'(w_t - C_W'(l));
      assign w_a_addr[l] = ba_q + ADDR_W'(w_t - C_W'(l));

      assign bus.ram_w_addr[l*ADDR_W +: ADDR_W] = w_w_rden[l] ? w_w_addr[l] : w_addr_q[l];
      assign bus.ram_a_addr[l*ADDR_W +: ADDR_W] = w_a_rden[l] ? w_a_addr[l] : a_addr_q[l];
    end

    for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
        localparam int M0 = i + j + RD_LAT;
        localparam int A0 = M0 + MUL_LAT;
        assign w_en_mult[i*N+j]  = w_active && (w_t >= C_W'(M0)) && (w_t < C_W'(M0) + w_k);
        assign w_en_accum[i*N+j] = w_active && (w_t >= C_W'(A0)) && (w_t < C_W'(A0) + w_k);
      end
    end
  endgenerate

  assign bus.ram_w_rden = w_w_rden;
  assign bus.ram_a_rden = w_a_rden;
  assign bus.en_mult    = w_en_mult;
  assign bus.en_accum   = w_en_accum;
  assign bus.clr_mult   = {(N*N){state_q == S_CLR}};
  assign bus.clr_accum  = {(N*N){state_q == S_CLR}};
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      k_q     <= '0;
      bw_q    <= '0;
      ba_q    <= '0;
      for (int l = 0; l < N; l++) begin
        w_addr_q[l] <= '0;
        a_addr_q[l] <= '0;
      end
    end else begin
      for (int l = 0; l < N; l++) begin
        if (w_w_rden[l]) w_addr_q[l] <= w_w_addr[l];
        if (w_a_rden[l]) a_addr_q[l] <= w_a_addr[l];
      end

      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            k_q     <= bus.k_len;
            bw_q    <= bus.base_w;
            ba_q    <= bus.base_a;
            state_q <= (bus.k_len == '0) ? S_DONE : S_CLR;
          end
        end
        S_CLR: begin
          t_q     <= '0;
          state_q <= S_RUN;
        end
        S_RUN, S_STALL: begin
          if (bus.stall) begin
            state_q <= S_STALL;
          end else if (w_last) begin
            state_q <= S_DONE;
          end else begin
            t_q     <= t_q + T_W'(1);
            state_q <= S_RUN;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_tile_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_systolic_tile_ctrl : directed tiles, per-cycle expected-output scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_systolic_tile_ctrl;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int KW = 8;
  localparam int RD = 1;
  localparam int ML = 1;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic [N*N-1:0]    clr_m;
    logic [N*N-1:0]    clr_a;
    logic [N*N-1:0]    en_m;
    logic [N*N-1:0]    en_a;
    logic [N-1:0]      w_rd;
    logic [N-1:0]      a_rd;
    logic [N*AW-1:0]   w_ad;
    logic [N*AW-1:0]   a_ad;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;

  systolic_tile_ctrl_if #(.N(N), .ADDR_W(AW), .K_W(KW)) bus ();

  systolic_tile_ctrl #(
    .N(N), .ADDR_W(AW), .K_W(KW), .RD_LAT(RD), .MUL_LAT(ML)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  obs_t          exp_q [$];
  logic [AW-1:0] hw [N];
  logic [AW-1:0] ha [N];
  int            n_assert = 0;
  int            n_fail   = 0;
  int            cyc      = 0;

  function automatic obs_t held(input logic b);
    obs_t e;
    e = '0;
    e.busy = b;
    for (int i = 0; i < N; i++) begin
      e.w_ad[i*AW +: AW] = hw[i];
      e.a_ad[i*AW +: AW] = ha[i];
    end
    return e;
  endfunction

  // Expected outputs of RUN step t; also advances the held-address model
  function automatic obs_t run_exp(input int t, input int k, input logic [AW-1:0] bw,
                                   input logic [AW-1:0] ba);
    obs_t e;
    for (int i = 0; i < N; i++) begin
      if (t >= i && t < i + k) begin
        hw[i] = bw + AW'(t - i);
        ha[i] = ba + AW'(t - i);
      end
    end
    e = held(1'b1);
    for (int i = 0; i < N; i++) begin
      e.w_rd[i] = (t >= i && t < i + k);
      e.a_rd[i] = (t >= i && t < i + k);
      for (int j = 0; j < N; j++) begin
        e.en_m[i*N+j] = (t >= i + j + RD) && (t < i + j + RD + k);
        e.en_a[i*N+j] = (t >= i + j + RD + ML) && (t < i + j + RD + ML + k);
      end
    end
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a.busy  = bus.busy;
    a.done  = bus.done;
    a.clr_m = bus.clr_mult;
    a.clr_a = bus.clr_accum;
    a.en_m  = bus.en_mult;
    a.en_a  = bus.en_accum;
    a.w_rd  = bus.ram_w_rden;
    a.a_rd  = bus.ram_a_rden;
    a.w_ad  = bus.ram_w_addr;
    a.a_ad  = bus.ram_a_addr;
    return a;
  endfunction

  // Inputs for this cycle are already driven; compare mid-cycle, return just after next edge
  task automatic step(input obs_t e_in, input string tag);
    obs_t a;
    obs_t e;
    exp_q.push_back(e_in);
    @(negedge clk);
    a = sample();
    e = exp_q.pop_front();
    n_assert++;
    assert ({a.busy, a.done, a.clr_m, a.clr_a} === {e.busy, e.done, e.clr_m, e.clr_a})
      else begin
        n_fail++;
        $error("FAIL %s_ctrl cyc=%0d observed=%h expected=%h", tag, cyc,
               {a.busy, a.done, a.clr_m, a.clr_a}, {e.busy, e.done, e.clr_m, e.clr_a});
      end
    n_assert++;
    assert ({a.w_rd, a.a_rd, a.w_ad, a.a_ad} === {e.w_rd, e.a_rd, e.w_ad, e.a_ad})
      else begin
        n_fail++;
        $error("FAIL %s_ram cyc=%0d observed=%h expected=%h", tag, cyc,
               {a.w_rd, a.a_rd, a.w_ad, a.a_ad}, {e.w_rd, e.a_rd, e.w_ad, e.a_ad});
      end
    n_assert++;
    assert ({a.en_m, a.en_a} === {e.en_m, e.en_a})
      else begin
        n_fail++;
        $error("FAIL %s_pe cyc=%0d observed=%h expected=%h", tag, cyc,
               {a.en_m, a.en_a}, {e.en_m, e.en_a});
      end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // One tile from its start cycle through the IDLE cycle after done.
  // stall_t/stall_n: stall inserted before RUN step stall_t; restart_t: start pulsed at that
  // RUN step; abort_t: rst_n pulled low at that RUN step; pre_stall: stall high in start/CLR.
  task automatic tile(input int k, input logic [AW-1:0] bw, input logic [AW-1:0] ba,
                      input int stall_t, input int stall_n, input bit pre_stall,
                      input int restart_t, input int abort_t);
    int T;
    T = k + 2 * (N - 1) + RD + ML;
    bus.start  = 1'b1;
    bus.k_len  = KW'(k);
    bus.base_w = bw;
    bus.base_a = ba;
    bus.stall  = pre_stall;
    step(held(1'b0), "start");
    bus.start  = 1'b0;
    bus.k_len  = KW'($urandom_range(0, 255));
    bus.base_w = AW'($urandom_range(0, 255));
    bus.base_a = AW'($urandom_range(0, 255));
    if (k == 0) begin
      bus.stall = 1'b0;
      begin
        obs_t e;
        e = held(1'b1);
        e.done = 1'b1;
        step(e, "done_k0");
      end
    end else begin
      begin
        obs_t e;
        e = held(1'b1);
        e.clr_m = '1;
        e.clr_a = '1;
        step(e, "clr");
      end
      bus.stall = 1'b0;
      for (int t = 0; t < T; t++) begin
        if (t == stall_t) begin
          for (int s = 0; s < stall_n; s++) begin
            bus.stall = 1'b1;
            step(held(1'b1), "stall");
          end
          bus.stall = 1'b0;
        end
        if (t == abort_t) begin
          rst_n = 1'b0;
          for (int i = 0; i < N; i++) begin
            hw[i] = '0;
            ha[i] = '0;
          end
          step('0, "abort");
          rst_n = 1'b1;
          step(held(1'b0), "idle_after_rst");
          return;
        end
        bus.start = (t == restart_t);
        step(run_exp(t, k, bw, ba), "run");
        bus.start = 1'b0;
      end
      begin
        obs_t e;
        e = held(1'b1);
        e.done = 1'b1;
        step(e, "done");
      end
    end
    step(held(1'b0), "idle_after");
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.k_len  = '0;
    bus.base_w = '0;
    bus.base_a = '0;
    bus.stall  = 1'b0;
    for (int i = 0; i < N; i++) begin
      hw[i] = '0;
      ha[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    step('0, "reset");
    rst_n = 1'b1;
    step(held(1'b0), "idle");

    tile(4, 8'h10, 8'h20, -1, 0, 1'b0, -1, -1);
    tile(4, 8'h10, 8'h20,  2, 3, 1'b0, -1, -1);
    tile(4, 8'hFE, 8'h05, -1, 0, 1'b0, -1, -1);
    tile(0, 8'h33, 8'h44, -1, 0, 1'b0, -1, -1);
    tile(3, 8'h40, 8'h50,  0, 1, 1'b1,  2, -1);
    tile(4, 8'h10, 8'h20, -1, 0, 1'b0, -1,  3);
    tile(2, 8'h70, 8'hFF,  1, 2, 1'b0, -1, -1);
    tile(255, 8'h80, 8'h00, 100, 1, 1'b0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
